// File: rtl/reel_round_ctrl_if.sv
// Signal bundle between the slot-game round controller and its surroundings:
// KEY/SW request, raw reel values in; reel enables, symbols, credits and status out.
interface reel_round_ctrl_if;
  logic       spin_req;
  logic [2:0] reel0;
  logic [2:0] reel1;
  logic [2:0] reel2;
  logic [2:0] reel_run;
  logic [1:0] sym0;
  logic [1:0] sym1;
  logic [1:0] sym2;
  logic [6:0] credits;
  logic       busy;
  logic [1:0] result;
  logic       result_valid;
  logic       game_over;

  modport master (
    output spin_req, reel0, reel1, reel2,
    input  reel_run, sym0, sym1, sym2, credits, busy, result, result_valid, game_over
  );

  modport slave (
    input  spin_req, reel0, reel1, reel2,
    output reel_run, sym0, sym1, sym2, credits, busy, result, result_valid, game_over
  );
endinterface

// File: rtl/reel_round_ctrl.sv
// Round controller: charges a credit, spins three reels, stops them on one-second
// boundaries, latches symbols (reel mod 3), scores the round and updates credits.
module reel_round_ctrl #(
  parameter int TICK_DIV      = 50_000_000,
  parameter int SPIN_SECS     = 2,
  parameter int STOP_GAP_SECS = 1,
  parameter int START_CREDITS = 10,
  parameter int WIN_CREDITS   = 5,
  parameter int PAIR_CREDITS  = 1
) (
  input logic              clk,
  input logic              reset,
  reel_round_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SPIN  = 3'd1;
  localparam logic [2:0] S_STOP1 = 3'd2;
  localparam logic [2:0] S_STOP2 = 3'd3;
  localparam logic [2:0] S_EVAL  = 3'd4;

  localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [7:0]    SPIN_LAST = 8'(SPIN_SECS - 1);
  localparam logic [7:0]    GAP_LAST  = 8'(STOP_GAP_SECS - 1);
  localparam logic [6:0]    START_C   = 7'(START_CREDITS);
  localparam logic [7:0]    WIN_C     = 8'(WIN_CREDITS);
  localparam logic [7:0]    PAIR_C    = 8'(PAIR_CREDITS);

  function automatic logic [1:0] mod3(input logic [2:0] v);
    logic [1:0] r;
    case (v)
      3'd0:    r = 2'd0;
      3'd1:    r = 2'd1;
      3'd2:    r = 2'd2;
      3'd3:    r = 2'd0;
      3'd4:    r = 2'd1;
      3'd5:    r = 2'd2;
      3'd6:    r = 2'd0;
      3'd7:    r = 2'd1;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  // Balance never exceeds 99, so a 9-bit sum cannot overflow before clamping.
  function automatic logic [6:0] sat_add(input logic [6:0] c, input logic [7:0] a);
    logic [8:0] s;
    logic [6:0] r;
    s = {2'b00, c} + {1'b0, a};
    if (s > 9'd99) begin
      r = 7'd99;
    end else begin
      r = s[6:0];
    end
    return r;
  endfunction

  logic [2:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    secs_q, secs_d;
  logic          prev_q, prev_d;
  logic [2:0]    run_q, run_d;
  logic [1:0]    sym0_q, sym0_d, sym1_q, sym1_d, sym2_q, sym2_d;
  logic [6:0]    credits_q, credits_d;
  logic          busy_q, busy_d;
  logic [1:0]    result_q, result_d;
  logic          rv_q, rv_d;
  logic          go_q, go_d;
  logic          tick_s, accept_s, triple_s, pair_s;

  // Next-state logic: round sequencing, symbol latching, scoring and credit update.
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    secs_d    = secs_q;
    prev_d    = bus.spin_req;
    run_d     = run_q;
    sym0_d    = sym0_q;
    sym1_d    = sym1_q;
    sym2_d    = sym2_q;
    credits_d = credits_q;
    busy_d    = busy_q;
    result_d  = result_q;
    rv_d      = 1'b0;

    tick_s   = (presc_q == PRESC_MAX);
    accept_s = bus.spin_req & ~prev_q;
    triple_s = (sym0_q == sym1_q) && (sym1_q == sym2_q);
    pair_s   = (sym0_q == sym1_q) || (sym1_q == sym2_q) || (sym0_q == sym2_q);

    case (state_q)
      S_IDLE: begin
        if (accept_s && (credits_q != 7'd0)) begin
          credits_d = credits_q - 7'd1;
          busy_d    = 1'b1;
          run_d     = 3'b111;
          presc_d   = '0;
          secs_d    = 8'd0;
          state_d   = S_SPIN;
        end else begin
          busy_d = 1'b0;
        end
      end
      S_SPIN, S_STOP1, S_STOP2: begin
        presc_d = tick_s ? '0 : presc_q + PW'(1);
        if (tick_s) begin
          secs_d = secs_q + 8'd1;
          if ((state_q == S_SPIN) && (secs_q == SPIN_LAST)) begin
            sym0_d   = mod3(bus.reel0);
            run_d[0] = 1'b0;
            secs_d   = 8'd0;
            state_d  = S_STOP1;
          end else if ((state_q == S_STOP1) && (secs_q == GAP_LAST)) begin
            sym1_d   = mod3(bus.reel1);
            run_d[1] = 1'b0;
            secs_d   = 8'd0;
            state_d  = S_STOP2;
          end else if ((state_q == S_STOP2) && (secs_q == GAP_LAST)) begin
            sym2_d   = mod3(bus.reel2);
            run_d[2] = 1'b0;
            secs_d   = 8'd0;
            state_d  = S_EVAL;
          end else begin
            state_d = state_q;
          end
        end else begin
          secs_d = secs_q;
        end
      end
      S_EVAL: begin
        if (triple_s) begin
          result_d  = 2'd2;
          credits_d = sat_add(credits_q, WIN_C);
        end else if (pair_s) begin
          result_d  = 2'd1;
          credits_d = sat_add(credits_q, PAIR_C);
        end else begin
          result_d  = 2'd0;
        end
        rv_d    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        run_d   = 3'b000;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign go_d = (state_d == S_IDLE) && (credits_d == 7'd0);

  // State registers with synchronous reset; the request history resets high.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      secs_q    <= 8'd0;
      prev_q    <= 1'b1;
      run_q     <= 3'b000;
      sym0_q    <= 2'd0;
      sym1_q    <= 2'd0;
      sym2_q    <= 2'd0;
      credits_q <= START_C;
      busy_q    <= 1'b0;
      result_q  <= 2'd0;
      rv_q      <= 1'b0;
      go_q      <= (START_C == 7'd0);
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      secs_q    <= secs_d;
      prev_q    <= prev_d;
      run_q     <= run_d;
      sym0_q    <= sym0_d;
      sym1_q    <= sym1_d;
      sym2_q    <= sym2_d;
      credits_q <= credits_d;
      busy_q    <= busy_d;
      result_q  <= result_d;
      rv_q      <= rv_d;
      go_q      <= go_d;
    end
  end

  assign bus.reel_run     = run_q;
  assign bus.sym0         = sym0_q;
  assign bus.sym1         = sym1_q;
  assign bus.sym2         = sym2_q;
  assign bus.credits      = credits_q;
  assign bus.busy         = busy_q;
  assign bus.result       = result_q;
  assign bus.result_valid = rv_q;
  assign bus.game_over    = go_q;

endmodule

// File: tb/tb_reel_round_ctrl.sv
// Scoreboard bench for reel_round_ctrl: two instances (START_CREDITS 2 and 98),
// directed rounds with hand-computed expectations checked on result_valid.
module tb_reel_round_ctrl;

  typedef struct packed {
    logic [1:0] res;
    logic [6:0] cred;
    logic [1:0] s0;
    logic [1:0] s1;
    logic [1:0] s2;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_s [2];
  logic       spin_s[2];
  logic [2:0] reel_s[2][3];
  logic [2:0] run_s [2];
  logic [1:0] sym_s [2][3];
  logic [6:0] cred_s[2];
  logic       busy_s[2];
  logic [1:0] res_s [2];
  logic       rv_s  [2];
  logic       go_s  [2];

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  int   n_cmp = 0;
  int   n_err = 0;

  reel_round_ctrl_if ifa ();
  reel_round_ctrl_if ifb ();

  reel_round_ctrl #(.TICK_DIV(4), .SPIN_SECS(2), .STOP_GAP_SECS(1), .START_CREDITS(2),
                    .WIN_CREDITS(5), .PAIR_CREDITS(1))
    u_dut_a (.clk(clk), .reset(rst_s[0]), .bus(ifa.slave));

  reel_round_ctrl #(.TICK_DIV(4), .SPIN_SECS(2), .STOP_GAP_SECS(1), .START_CREDITS(98),
                    .WIN_CREDITS(5), .PAIR_CREDITS(1))
    u_dut_b (.clk(clk), .reset(rst_s[1]), .bus(ifb.slave));

  assign ifa.spin_req = spin_s[0];
  assign ifa.reel0    = reel_s[0][0];
  assign ifa.reel1    = reel_s[0][1];
  assign ifa.reel2    = reel_s[0][2];
  assign run_s[0]     = ifa.reel_run;
  assign sym_s[0][0]  = ifa.sym0;
  assign sym_s[0][1]  = ifa.sym1;
  assign sym_s[0][2]  = ifa.sym2;
  assign cred_s[0]    = ifa.credits;
  assign busy_s[0]    = ifa.busy;
  assign res_s[0]     = ifa.result;
  assign rv_s[0]      = ifa.result_valid;
  assign go_s[0]      = ifa.game_over;

  assign ifb.spin_req = spin_s[1];
  assign ifb.reel0    = reel_s[1][0];
  assign ifb.reel1    = reel_s[1][1];
  assign ifb.reel2    = reel_s[1][2];
  assign run_s[1]     = ifb.reel_run;
  assign sym_s[1][0]  = ifb.sym0;
  assign sym_s[1][1]  = ifb.sym1;
  assign sym_s[1][2]  = ifb.sym2;
  assign cred_s[1]    = ifb.credits;
  assign busy_s[1]    = ifb.busy;
  assign res_s[1]     = ifb.result;
  assign rv_s[1]      = ifb.result_valid;
  assign go_s[1]      = ifb.game_over;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pop expected round outcome whenever a DUT presents result_valid.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_s[d] && rv_s[d]) begin
        exp_t e;
        if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
          check($sformatf("dut%0d_unexpected_result_valid", d), 1, 0);
        end else begin
          if (d == 0) e = exp_q0.pop_front();
          else        e = exp_q1.pop_front();
          check($sformatf("dut%0d_result", d),  int'(res_s[d]),    int'(e.res));
          check($sformatf("dut%0d_credits", d), int'(cred_s[d]),   int'(e.cred));
          check($sformatf("dut%0d_sym0", d),    int'(sym_s[d][0]), int'(e.s0));
          check($sformatf("dut%0d_sym1", d),    int'(sym_s[d][1]), int'(e.s1));
          check($sformatf("dut%0d_sym2", d),    int'(sym_s[d][2]), int'(e.s2));
        end
      end
    end
  end

  task automatic push_exp(input int d, input exp_t e);
    if (d == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  // One full round: edge on spin_req, measure reel enable widths and result pulse.
  task automatic run_round(input int d, input logic [2:0] r0, input logic [2:0] r1,
                           input logic [2:0] r2, input int pre_cred, input exp_t e,
                           input bit mid_edge);
    int  c0 = 0, c1 = 0, c2 = 0, rv = 0;
    bit  done = 1'b0;
    reel_s[d][0] = r0;
    reel_s[d][1] = r1;
    reel_s[d][2] = r2;
    push_exp(d, e);
    @(negedge clk);
    spin_s[d] = 1'b0;
    @(negedge clk);
    spin_s[d] = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check("start_busy", int'(busy_s[d]), 1);
        check("start_credits", int'(cred_s[d]), pre_cred - 1);
        check("start_reel_run", int'(run_s[d]), 7);
      end
      if (run_s[d][0]) c0++;
      if (run_s[d][1]) c1++;
      if (run_s[d][2]) c2++;
      if (rv_s[d]) rv++;
      if (mid_edge && c == 2) spin_s[d] = 1'b0;
      if (mid_edge && c == 3) spin_s[d] = 1'b1;
      if (c > 0 && !busy_s[d]) done = 1'b1;
    end
    check("round_timeout", int'(done), 1);
    check("reel0_run_cycles", c0, 8);
    check("reel1_run_cycles", c1, 12);
    check("reel2_run_cycles", c2, 16);
    check("result_valid_cycles", rv, 1);
    if (mid_edge) begin
      repeat (3) @(negedge clk);
      check("no_second_round_busy", int'(busy_s[d]), 0);
    end
    spin_s[d] = 1'b0;
  endtask

  initial begin
    bit reached;
    rst_s[0] = 1'b1;
    rst_s[1] = 1'b1;
    spin_s[0] = 1'b1;
    spin_s[1] = 1'b1;
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 3; k++) reel_s[d][k] = 3'd0;
    repeat (3) @(negedge clk);
    rst_s[0] = 1'b0;
    rst_s[1] = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_busy", int'(busy_s[0]), 0);
    check("rst_reel_run", int'(run_s[0]), 0);
    check("rst_credits_a", int'(cred_s[0]), 2);
    check("rst_credits_b", int'(cred_s[1]), 98);
    check("rst_sym0", int'(sym_s[0][0]), 0);
    check("rst_result", int'(res_s[0]), 0);
    check("rst_result_valid", int'(rv_s[0]), 0);
    check("rst_game_over", int'(go_s[0]), 0);

    // Triple 3,6,0 -> 0,0,0: 2-1+5 = 6.
    run_round(0, 3'd3, 3'd6, 3'd0, 2, '{res: 2'd2, cred: 7'd6, s0: 2'd0, s1: 2'd0, s2: 2'd0}, 1'b0);
    // Pair 1,4,2 -> 1,1,2: 6-1+1 = 6.
    run_round(0, 3'd1, 3'd4, 3'd2, 6, '{res: 2'd1, cred: 7'd6, s0: 2'd1, s1: 2'd1, s2: 2'd2}, 1'b0);
    // No-match rounds 0,1,2 drain the balance 6 -> 0; first one also has a spin edge mid-SPIN.
    for (int k = 6; k >= 1; k--)
      run_round(0, 3'd0, 3'd1, 3'd2, k,
                '{res: 2'd0, cred: 7'(k - 1), s0: 2'd0, s1: 2'd1, s2: 2'd2}, (k == 6));
    check("game_over_set", int'(go_s[0]), 1);
    check("credits_zero", int'(cred_s[0]), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      spin_s[0] = 1'b1;
      repeat (2) @(negedge clk);
      check("no_credit_busy", int'(busy_s[0]), 0);
      check("no_credit_reel_run", int'(run_s[0]), 0);
      spin_s[0] = 1'b0;
    end

    // Saturation: 98-1+5 clamps at 99.
    run_round(1, 3'd3, 3'd6, 3'd0, 98, '{res: 2'd2, cred: 7'd99, s0: 2'd0, s1: 2'd0, s2: 2'd0}, 1'b0);

    // Abort in STOP1: sym0 latches 1, then reset restores every output.
    reel_s[1][0] = 3'd1;
    reel_s[1][1] = 3'd1;
    reel_s[1][2] = 3'd1;
    @(negedge clk);
    spin_s[1] = 1'b0;
    @(negedge clk);
    spin_s[1] = 1'b1;
    @(negedge clk);
    check("abort_start_credits", int'(cred_s[1]), 98);
    reached = 1'b0;
    for (int c = 0; c < 20 && !reached; c++) begin
      @(negedge clk);
      if (run_s[1] == 3'b110) reached = 1'b1;
    end
    check("reach_stop1", int'(reached), 1);
    check("stop1_sym0", int'(sym_s[1][0]), 1);
    rst_s[1] = 1'b1;
    @(negedge clk);
    check("abort_reel_run", int'(run_s[1]), 0);
    check("abort_busy", int'(busy_s[1]), 0);
    check("abort_credits", int'(cred_s[1]), 98);
    check("abort_sym0", int'(sym_s[1][0]), 0);
    check("abort_result", int'(res_s[1]), 0);
    check("abort_result_valid", int'(rv_s[1]), 0);
    check("abort_game_over", int'(go_s[1]), 0);
    rst_s[1] = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_stays_idle", int'(busy_s[1]), 0);

    check("pending_exp_a", exp_q0.size(), 0);
    check("pending_exp_b", exp_q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reel_round_ctrl.md
# reel_round_ctrl

Round controller for the three-reel slot game on the DE1-SoC. It accepts a spin request and charges one credit per round. It runs the three LFSR reels and stops them one at a time on one-second boundaries, then latches each reel's symbol (value mod 3). After the last reel stops, it scores the round and updates a saturating credit balance. It sits between the KEY/SW inputs, the `lfsr` reel instances (driving their enables) and the `hex_decoder` displays (supplying symbols and credits).

## Interface
Parameters:
- `TICK_DIV`, 50_000_000: `clk` cycles per one-second tick.
- `SPIN_SECS`, 2: seconds all reels spin before reel 0 stops (≥1).
- `STOP_GAP_SECS`, 1: seconds between successive reel stops (≥1).
- `START_CREDITS`, 10: credit balance after reset (0..99).
- `WIN_CREDITS`, 5: credits added when all three symbols match.
- `PAIR_CREDITS`, 1: credits added when exactly two symbols match.

Ports:
- `clk`  in  1  system clock (CLOCK_50).
- `reset`  in  1  synchronous, active-high reset.
- `spin_req`  in  1  level request; acted on at its 0→1 transition.
- `reel0`, `reel1`, `reel2`  in  3 each  raw LFSR reel values.
- `reel_run`  out  3  bit i high = reel i LFSR enabled (advancing).
- `sym0`, `sym1`, `sym2`  out  2 each  latched symbols, 0..2.
- `credits`  out  7  credit balance, 0..99.
- `busy`  out  1  high while a round is in progress.
- `result`  out  2  last round: 0 none, 1 pair, 2 triple.
- `result_valid`  out  1  one-cycle pulse when `result`/`credits` update.
- `game_over`  out  1  high when idle and `credits`==0.

## Operation
- Reset values: state IDLE, `reel_run`=000, `sym*`=0, `credits`=START_CREDITS, `busy`=0, `result`=0, `result_valid`=0, prescaler=0, second count=0, spin_req history register=1. Because the history register resets to 1, a request held high through reset must be released and re-asserted before it is accepted.
- Edge detect: accepted = `spin_req` & ~prev, where prev is `spin_req` registered last cycle.
- States: IDLE → SPIN → STOP1 → STOP2 → EVAL → IDLE.
- IDLE: if accepted and `credits`>0, set `credits` −1, `busy` 1, `reel_run` 111, prescaler 0, seconds 0, and go to SPIN. If `credits`==0 the edge is ignored.
- Prescaler: counts 0..TICK_DIV−1 in SPIN/STOP1/STOP2. A tick is the cycle where it equals TICK_DIV−1; it wraps to 0 on the tick. The seconds counter increments per tick and clears on each state change.
- SPIN: on the tick completing SPIN_SECS seconds, latch `sym0`=`reel0` mod 3, clear `reel_run[0]`, and go to STOP1.
- STOP1: after STOP_GAP_SECS seconds, latch `sym1`, clear `reel_run[1]`, and go to STOP2.
- STOP2: after STOP_GAP_SECS seconds, latch `sym2`, clear `reel_run[2]`, and go to EVAL.
- EVAL (one cycle): score the round and go to IDLE.
  - Triple: `result`=2, add WIN_CREDITS.
  - Exactly two equal: `result`=1, add PAIR_CREDITS.
  - Otherwise: `result`=0.
  - `result_valid`=1 for this cycle; `busy` drops on return to IDLE.
- Mod 3 of a 3-bit value: 0,1,2,3,4,5,6,7 → 0,1,2,0,1,2,0,1.
- Credit addition saturates at 99. Subtraction never underflows, because a round is only started with `credits`>0.
- Spin edges during SPIN/STOP1/STOP2/EVAL are ignored (not queued). Reel inputs are sampled only on latch cycles.
- Reset in any state aborts the round immediately; the charged credit is not refunded (balance returns to START_CREDITS).

## Timing
- All outputs are registered.
- Request at cycle T with prev=0 → `busy`, `reel_run`=111 and decremented `credits` visible at T+1.
- `reel_run[0]` stays high for exactly SPIN_SECS·TICK_DIV cycles.
- `reel_run[1]` stays high for exactly (SPIN_SECS+STOP_GAP_SECS)·TICK_DIV cycles.
- `reel_run[2]` stays high for exactly (SPIN_SECS+2·STOP_GAP_SECS)·TICK_DIV cycles.
- Each `sym` updates in the same cycle its `reel_run` bit falls. The latched value is the reel input sampled on that clock edge.
- `result_valid` pulses the cycle after `reel_run[2]` falls, together with the `result` and `credits` updates. `busy` falls the following cycle.
- A new request is accepted no earlier than the first IDLE cycle.

## Test plan
Bench parameters: TICK_DIV=4, SPIN_SECS=2, STOP_GAP_SECS=1, WIN_CREDITS=5, PAIR_CREDITS=1.
- START_CREDITS=2; `spin_req` held 1 through reset → no round starts. Drop it for 1 cycle, then raise it → `busy`=1 and `credits`=1 one cycle after the rise.
- START_CREDITS=2; reels held at 3,6,0 → `reel_run` bits 0/1/2 high 8/12/16 cycles; `sym`=0,0,0; `result`=2; `credits`=6 with a 1-cycle `result_valid`.
- START_CREDITS=2; reels held at 1,4,2 → `sym`=1,1,2; `result`=1; `credits`=2.
- START_CREDITS=1; reels 0,1,2 → `result`=0, `credits`=0, `game_over`=1. Further spin edges leave `busy`=0 and `reel_run`=000.
- START_CREDITS=98; triple round → `credits` goes 97 then saturates at 99.
- Spin edge during SPIN → round timing unchanged, no second round. `reset` asserted in STOP1 → next cycle all outputs at reset values and `credits`=START_CREDITS.
